// File: rtl/tl_mem_slave.sv
// TileLink-UL responder backed by a 64-bit word RAM; one request in flight at a time.
// Optional build macro TL_MEM_RANGE_CHECK_EN adds an address range check that flags errors.
module tl_mem_slave #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_size,
    input  logic [63:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic        d_error,
    output logic [63:0] d_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [2:0]  op_q;
    logic [2:0]  size_q;
    logic [63:0] addr_q;
    logic [7:0]  mask_q;
    logic [63:0] data_q;

    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             unused_offset_bits;
    logic             is_get;
    logic             is_put;
    logic             misaligned;
    logic             bad_req;
    logic             out_of_range;
    logic             do_write;

    assign offset             = addr_q - BASE_ADDR;
    assign idx                = offset[IDX_W+2:3];
    assign unused_offset_bits = ^{offset[63:IDX_W+3], offset[2:0]};

    assign is_get = (op_q == 3'd4);
    assign is_put = (op_q == 3'd0) || (op_q == 3'd1);

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            3'd1:    misaligned = addr_q[0];
            3'd2:    misaligned = |addr_q[1:0];
            3'd3:    misaligned = |addr_q[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign bad_req = !(is_get || is_put) || (size_q > 3'd3) || misaligned;

`ifdef TL_MEM_RANGE_CHECK_EN
    // 65-bit limit so a base near the top of the address space cannot wrap
    localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + 65'(DEPTH_WORDS) * 65'd8;
    assign out_of_range = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= LIMIT);
`else
    assign out_of_range = 1'b0;
`endif

    assign a_ready  = (state == S_IDLE) && !rst;
    assign d_valid  = (state == S_RESP);
    assign do_write = (state == S_ACCESS) && !rst && is_put && !bad_req && !out_of_range;

    // RAM is never reset so program/data images survive a core reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 8; k++) begin
                if (mask_q[k]) mem[idx][8*k +: 8] <= data_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            op_q     <= 3'd0;
            size_q   <= 3'd0;
            addr_q   <= 64'd0;
            mask_q   <= 8'd0;
            data_q   <= 64'd0;
            d_opcode <= 3'd0;
            d_error  <= 1'b0;
            d_data   <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_valid) begin
                        op_q     <= a_opcode;
                        size_q   <= a_size;
                        addr_q   <= a_address;
                        mask_q   <= a_mask;
                        data_q   <= a_data;
                        wait_cnt <= 4'(WAIT_CYCLES - 1);
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_ACCESS;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_ACCESS: begin
                    // malformed requests report AccessAck regardless of the opcode asked for
                    if (bad_req) begin
                        d_opcode <= 3'd0;
                        d_error  <= 1'b1;
                        d_data   <= 64'd0;
                    end else if (out_of_range) begin
                        d_opcode <= is_get ? 3'd1 : 3'd0;
                        d_error  <= 1'b1;
                        d_data   <= 64'd0;
                    end else if (is_get) begin
                        d_opcode <= 3'd1;
                        d_error  <= 1'b0;
                        d_data   <= mem[idx];
                    end else begin
                        d_opcode <= 3'd0;
                        d_error  <= 1'b0;
                        d_data   <= 64'd0;
                    end
                    state <= S_RESP;
                end
                default: begin
                    if (d_ready) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
